reg_scoreboard: RTL and testbench

- Register scoreboard that gates issue from the decode stage to execute.
- Tracks outstanding writes per architectural register for in-flight instructions: loads and multi-cycle ops.
- Stalls decode when a source operand (ra1/ra2) or the destination counter is unavailable.
- Sits beside decode; consumes decode's register addresses and control, and the writeback/squash events from later stages.

---
 rtl/pipes.sv | 13 +
 rtl/sb_counter.sv | 52 +++++
 rtl/reg_scoreboard.sv | 123 ++++++++++++
 tb/tb_reg_scoreboard.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipes.sv
// Shared types and default sizing for the register scoreboard.
package pipes;

    localparam int unsigned SB_NREG         = 32;
    localparam int unsigned SB_CNT_W        = 2;
    localparam int unsigned SB_MAX_INFLIGHT = 4;
    localparam int unsigned SB_INFLIGHT_W   = $clog2(SB_MAX_INFLIGHT + 1);

    typedef logic [4:0]               creg_addr_t;
    typedef logic [SB_CNT_W-1:0]      sb_cnt_t;
    typedef logic [SB_INFLIGHT_W-1:0] sb_inflight_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: one increment and two decrement
// sources per cycle, net change applied, excess decrements dropped.
module sb_counter
    import pipes::*;
#(
    parameter int unsigned W = SB_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    input  logic         i_dec_a,
    input  logic         i_dec_b,
    output logic [W-1:0] o_count,
    output logic [1:0]   o_underflow,
    output logic         o_overflow
);

    logic [W-1:0] r_count;
    logic [W:0]   w_up;
    logic [W:0]   w_dn;
    logic [W:0]   w_diff;
    logic [W-1:0] w_next;

    // Net step; decrements below zero are dropped and counted, an overflowing increment holds the count.
    always_comb begin
        w_up        = {1'b0, r_count} + {{W{1'b0}}, i_inc};
        w_dn        = {{W{1'b0}}, i_dec_a} + {{W{1'b0}}, i_dec_b};
        w_diff      = w_up - w_dn;
        w_next      = w_diff[W-1:0];
        o_underflow = '0;
        o_overflow  = 1'b0;
        if (w_dn > w_up) begin
            o_underflow = 2'(w_dn - w_up);
            w_next      = '0;
        end else if (w_diff[W]) begin
            o_overflow  = 1'b1;
            w_next      = r_count;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes per architectural register
// and holds decode while a source, destination counter or the global
// in-flight budget is unavailable.
module reg_scoreboard
    import pipes::*;
#(
    parameter int unsigned NREG         = SB_NREG,
    parameter int unsigned CNT_W        = SB_CNT_W,
    parameter int unsigned MAX_INFLIGHT = SB_MAX_INFLIGHT,
    parameter int unsigned WB_BYPASS    = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 id_valid,
    input  creg_addr_t                           ra1,
    input  creg_addr_t                           ra2,
    input  logic                                 use_ra1,
    input  logic                                 use_ra2,
    input  creg_addr_t                           id_rd,
    input  logic                                 id_wen,
    input  logic                                 issue_ready,
    input  logic                                 wb_valid,
    input  creg_addr_t                           wb_rd,
    input  logic                                 kill_valid,
    input  creg_addr_t                           kill_rd,
    output logic                                 stall_d,
    output logic                                 issue_fire,
    output logic [NREG-1:0]                      busy_mask,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
    output logic                                 err
);

    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

    logic [CNT_W-1:0] w_pending [NREG];
    logic [1:0]       w_drop    [NREG];
    logic             w_ovf     [NREG];

    logic          w_dec_wb;
    logic          w_dec_kill;
    logic          w_inc;
    logic [1:0]    w_byp1;
    logic [1:0]    w_byp2;
    logic          w_haz_ra1;
    logic          w_haz_ra2;
    logic          w_haz_dst;
    logic          w_haz_cap;
    logic [2:0]    w_drop_total;
    logic [IW-1:0] w_inflight_next;
    logic [IW-1:0] r_inflight;
    logic          r_err;

    // x0 is never tracked.
    assign w_pending[0] = '0;
    assign w_drop[0]    = '0;
    assign w_ovf[0]     = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        sb_counter #(.W(CNT_W)) u_cnt (
            .i_clk       (clk),
            .i_reset     (reset),
            .i_inc       (w_inc && (id_rd == creg_addr_t'(g))),
            .i_dec_a     (w_dec_wb && (wb_rd == creg_addr_t'(g))),
            .i_dec_b     (w_dec_kill && (kill_rd == creg_addr_t'(g))),
            .o_count     (w_pending[g]),
            .o_underflow (w_drop[g]),
            .o_overflow  (w_ovf[g])
        );
    end

    for (genvar g = 0; g < NREG; g++) begin : g_busy
        assign busy_mask[g] = |w_pending[g];
    end

    // Hazard detection and issue handshake; a source is free once this cycle's retirements cover its pending count.
    always_comb begin
        w_dec_wb   = wb_valid && (wb_rd != '0);
        w_dec_kill = kill_valid && (kill_rd != '0);
        w_byp1     = '0;
        w_byp2     = '0;
        if (WB_BYPASS != 0) begin
            w_byp1 = {1'b0, w_dec_wb && (wb_rd == ra1)} + {1'b0, w_dec_kill && (kill_rd == ra1)};
            w_byp2 = {1'b0, w_dec_wb && (wb_rd == ra2)} + {1'b0, w_dec_kill && (kill_rd == ra2)};
        end
        w_haz_ra1  = use_ra1 && (ra1 != '0) && ((CNT_W+1)'(w_pending[ra1]) > (CNT_W+1)'(w_byp1));
        w_haz_ra2  = use_ra2 && (ra2 != '0) && ((CNT_W+1)'(w_pending[ra2]) > (CNT_W+1)'(w_byp2));
        w_haz_dst  = id_wen && (id_rd != '0) && (w_pending[id_rd] == '1)
                     && !((w_dec_wb && (wb_rd == id_rd)) || (w_dec_kill && (kill_rd == id_rd)));
        w_haz_cap  = id_wen && (id_rd != '0) && (r_inflight == IW'(MAX_INFLIGHT))
                     && !(w_dec_wb || w_dec_kill);
        stall_d    = reset || (id_valid && (w_haz_ra1 || w_haz_ra2 || w_haz_dst || w_haz_cap));
        issue_fire = id_valid && issue_ready && !stall_d;
        w_inc      = issue_fire && id_wen && (id_rd != '0);
    end

    // In-flight total follows the counters: decrements a counter dropped are added back, as is a held overflow.
    always_comb begin
        w_drop_total = '0;
        if (w_dec_wb) begin
            w_drop_total = {1'b0, w_drop[wb_rd]};
        end
        if (w_dec_kill && !(w_dec_wb && (kill_rd == wb_rd))) begin
            w_drop_total = w_drop_total + {1'b0, w_drop[kill_rd]};
        end
        w_inflight_next = r_inflight + IW'(w_inc) + IW'(w_drop_total)
                          - IW'(w_dec_wb) - IW'(w_dec_kill) - IW'(w_ovf[id_rd]);
    end

    // In-flight total and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_inflight_next;
            r_err      <= r_err || (w_drop_total != '0) || w_ovf[id_rd];
        end
    end

    assign inflight = r_inflight;
    assign err      = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus a randomized run
// against a per-register pending-count model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        use_ra1;
    logic        use_ra2;
    logic [4:0]  id_rd;
    logic        id_wen;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        kill_valid;
    logic [4:0]  kill_rd;
    logic        stall_d;
    logic        issue_fire;
    logic [31:0] busy_mask;
    logic [2:0]  inflight;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    int m_pend [32];
    bit m_err;

    always #5 clk = ~clk;

    reg_scoreboard #(
        .NREG         (32),
        .CNT_W        (2),
        .MAX_INFLIGHT (4),
        .WB_BYPASS    (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .ra1         (ra1),
        .ra2         (ra2),
        .use_ra1     (use_ra1),
        .use_ra2     (use_ra2),
        .id_rd       (id_rd),
        .id_wen      (id_wen),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .kill_valid  (kill_valid),
        .kill_rd     (kill_rd),
        .stall_d     (stall_d),
        .issue_fire  (issue_fire),
        .busy_mask   (busy_mask),
        .inflight    (inflight),
        .err         (err)
    );

    // ---------------- reference model ----------------
    function automatic int m_inflight();
        int s = 0;
        for (int r = 0; r < 32; r++) s += m_pend[r];
        return s;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++) b[r] = (m_pend[r] != 0);
        return b;
    endfunction

    // Number of retirements (writeback + squash) aimed at register r this cycle.
    function automatic int hits(input logic [4:0] r);
        if (r == 5'd0) return 0;
        return int'(wb_valid && (wb_rd == r)) + int'(kill_valid && (kill_rd == r));
    endfunction

    function automatic bit m_stall();
        bit h = 1'b0;
        if (reset) return 1'b1;
        if (!id_valid) return 1'b0;
        if (use_ra1 && ra1 != 5'd0 && (m_pend[ra1] - hits(ra1)) > 0) h = 1'b1;
        if (use_ra2 && ra2 != 5'd0 && (m_pend[ra2] - hits(ra2)) > 0) h = 1'b1;
        if (id_wen && id_rd != 5'd0 && m_pend[id_rd] == 3 && hits(id_rd) == 0) h = 1'b1;
        if (id_wen && id_rd != 5'd0 && m_inflight() == 4
            && !((wb_valid && wb_rd != 5'd0) || (kill_valid && kill_rd != 5'd0))) h = 1'b1;
        return h;
    endfunction

    function automatic bit m_fire();
        return id_valid && issue_ready && !m_stall();
    endfunction

    // Advance one clock and apply the same events to the model.
    task automatic tick();
        bit fire;
        fire = m_fire();
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 0;
            m_err = 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                int nxt;
                nxt = m_pend[r] + int'(fire && id_wen && (id_rd == 5'(r))) - hits(5'(r));
                if (nxt < 0) begin
                    m_err = 1'b1;
                    nxt   = 0;
                end
                if (nxt > 3) begin
                    m_err = 1'b1;
                    nxt   = m_pend[r];
                end
                m_pend[r] = nxt;
            end
        end
        #1;
    endtask

    task automatic idle();
        id_valid = 0; ra1 = 0; ra2 = 0; use_ra1 = 0; use_ra2 = 0;
        id_rd = 0; id_wen = 0; issue_ready = 0;
        wb_valid = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0;
    endtask

    task automatic issue_to(input logic [4:0] rd);
        idle();
        id_valid = 1; id_wen = 1; id_rd = rd; issue_ready = 1;
    endtask

    function automatic logic [4:0] pick();
        int q[$];
        for (int r = 1; r < 8; r++) if (m_pend[r] != 0) q.push_back(r);
        if (q.size() == 0 || $urandom_range(0, 7) == 0) return 5'($urandom_range(0, 7));
        return 5'(q[$urandom_range(0, q.size() - 1)]);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        reset = 1; id_valid = 1; issue_ready = 1; id_wen = 1; id_rd = 3;
        #1;
        n_cmp++; if (stall_d !== 1'b1) begin n_bad++; $display("FAIL rst_stall: got %b want 1", stall_d); end
        n_cmp++; if (issue_fire !== 1'b0) begin n_bad++; $display("FAIL rst_fire: got %b want 0", issue_fire); end
        tick();
        tick();
        n_cmp++; if (stall_d !== 1'b1) begin n_bad++; $display("FAIL rst_stall2: got %b want 1", stall_d); end
        reset = 0;
        idle();
        #1;
        n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL rst_busy: got %h want 0", busy_mask); end
        n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL rst_inflight: got %0d want 0", inflight); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (stall_d !== 1'b0) begin n_bad++; $display("FAIL rst_idle_stall: got %b want 0", stall_d); end
    endtask

    task automatic test_load_use();
        issue_to(5'd5);
        #1;
        n_cmp++; if (issue_fire !== 1'b1) begin n_bad++; $display("FAIL lu_issue: got %b want 1", issue_fire); end
        tick();
        idle();
        id_valid = 1; issue_ready = 1; ra1 = 5; use_ra1 = 1;
        #1;
        n_cmp++; if (busy_mask[5] !== 1'b1) begin n_bad++; $display("FAIL lu_busy5: got %b want 1", busy_mask[5]); end
        n_cmp++; if (inflight !== 3'd1) begin n_bad++; $display("FAIL lu_inflight: got %0d want 1", inflight); end
        n_cmp++; if (stall_d !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", stall_d); end
        n_cmp++; if (issue_fire !== 1'b0) begin n_bad++; $display("FAIL lu_nofire: got %b want 0", issue_fire); end
        tick();
        n_cmp++; if (stall_d !== 1'b1) begin n_bad++; $display("FAIL lu_hold: got %b want 1", stall_d); end
        wb_valid = 1; wb_rd = 5;
        #1;
        n_cmp++; if (stall_d !== 1'b0) begin n_bad++; $display("FAIL lu_wb_stall: got %b want 0", stall_d); end
        n_cmp++; if (issue_fire !== 1'b1) begin n_bad++; $display("FAIL lu_wb_fire: got %b want 1", issue_fire); end
        tick();
        idle();
        #1;
        n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL lu_clear: got %h want 0", busy_mask); end
        n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL lu_inflight0: got %0d want 0", inflight); end
    endtask

    task automatic test_bypass();
        issue_to(5'd7);
        tick();
        idle();
        id_valid = 1; issue_ready = 1; ra2 = 7; use_ra2 = 1;
        wb_valid = 1; wb_rd = 7;
        #1;
        n_cmp++; if (stall_d !== 1'b0) begin n_bad++; $display("FAIL byp_stall: got %b want 0", stall_d); end
        n_cmp++; if (issue_fire !== 1'b1) begin n_bad++; $display("FAIL byp_fire: got %b want 1", issue_fire); end
        tick();
        idle();
        #1;
        n_cmp++; if (busy_mask[7] !== 1'b0) begin n_bad++; $display("FAIL byp_busy7: got %b want 0", busy_mask[7]); end
        n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL byp_inflight: got %0d want 0", inflight); end
    endtask

    task automatic test_capacity();
        int drain [4] = '{2, 3, 4, 6};
        for (int r = 1; r <= 4; r++) begin
            issue_to(5'(r));
            tick();
        end
        idle();
        #1;
        n_cmp++; if (inflight !== 3'd4) begin n_bad++; $display("FAIL cap_full: got %0d want 4", inflight); end
        n_cmp++; if (busy_mask !== 32'h1E) begin n_bad++; $display("FAIL cap_busy: got %h want 1e", busy_mask); end
        issue_to(5'd6);
        #1;
        n_cmp++; if (stall_d !== 1'b1) begin n_bad++; $display("FAIL cap_stall: got %b want 1", stall_d); end
        wb_valid = 1; wb_rd = 1;
        #1;
        n_cmp++; if (stall_d !== 1'b0) begin n_bad++; $display("FAIL cap_wb_stall: got %b want 0", stall_d); end
        n_cmp++; if (issue_fire !== 1'b1) begin n_bad++; $display("FAIL cap_wb_fire: got %b want 1", issue_fire); end
        tick();
        idle();
        #1;
        n_cmp++; if (inflight !== 3'd4) begin n_bad++; $display("FAIL cap_after: got %0d want 4", inflight); end
        n_cmp++; if (busy_mask !== 32'h5C) begin n_bad++; $display("FAIL cap_busy2: got %h want 5c", busy_mask); end
        foreach (drain[i]) begin
            idle();
            wb_valid = 1; wb_rd = 5'(drain[i]);
            tick();
        end
        idle();
        #1;
        n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL cap_drain: got %0d want 0", inflight); end
    endtask

    task automatic test_dest_sat();
        for (int k = 0; k < 3; k++) begin
            issue_to(5'd9);
            tick();
        end
        idle();
        #1;
        n_cmp++; if (inflight !== 3'd3) begin n_bad++; $display("FAIL dst_cnt: got %0d want 3", inflight); end
        n_cmp++; if (busy_mask !== 32'h200) begin n_bad++; $display("FAIL dst_busy: got %h want 200", busy_mask); end
        issue_to(5'd9);
        #1;
        n_cmp++; if (stall_d !== 1'b1) begin n_bad++; $display("FAIL dst_stall: got %b want 1", stall_d); end
        kill_valid = 1; kill_rd = 9;
        #1;
        n_cmp++; if (stall_d !== 1'b0) begin n_bad++; $display("FAIL dst_kill_stall: got %b want 0", stall_d); end
        n_cmp++; if (issue_fire !== 1'b1) begin n_bad++; $display("FAIL dst_kill_fire: got %b want 1", issue_fire); end
        tick();
        idle();
        #1;
        n_cmp++; if (inflight !== 3'd3) begin n_bad++; $display("FAIL dst_keep: got %0d want 3", inflight); end
        for (int k = 0; k < 2; k++) begin
            idle();
            wb_valid = 1; wb_rd = 9;
            tick();
        end
        idle();
        #1;
        n_cmp++; if (busy_mask[9] !== 1'b1) begin n_bad++; $display("FAIL dst_busy_last: got %b want 1", busy_mask[9]); end
        n_cmp++; if (inflight !== 3'd1) begin n_bad++; $display("FAIL dst_one: got %0d want 1", inflight); end
        wb_valid = 1; wb_rd = 9;
        tick();
        idle();
        #1;
        n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL dst_empty: got %h want 0", busy_mask); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL dst_err: got %b want 0", err); end
    endtask

    task automatic test_x0_underflow();
        issue_to(5'd0);
        ra1 = 0; use_ra1 = 1;
        #1;
        n_cmp++; if (stall_d !== 1'b0) begin n_bad++; $display("FAIL x0_stall: got %b want 0", stall_d); end
        n_cmp++; if (issue_fire !== 1'b1) begin n_bad++; $display("FAIL x0_fire: got %b want 1", issue_fire); end
        tick();
        idle();
        #1;
        n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL x0_inflight: got %0d want 0", inflight); end
        n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL x0_busy: got %h want 0", busy_mask); end
        wb_valid = 1; wb_rd = 12;
        tick();
        idle();
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL uf_err: got %b want 1", err); end
        n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL uf_busy: got %h want 0", busy_mask); end
        n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL uf_inflight: got %0d want 0", inflight); end
    endtask

    task automatic test_reset_mid();
        for (int r = 1; r <= 3; r++) begin
            issue_to(5'(r));
            tick();
        end
        idle();
        #1;
        n_cmp++; if (inflight !== 3'd3) begin n_bad++; $display("FAIL rm_pre: got %0d want 3", inflight); end
        issue_to(5'd4);
        reset = 1;
        #1;
        n_cmp++; if (stall_d !== 1'b1) begin n_bad++; $display("FAIL rm_stall: got %b want 1", stall_d); end
        n_cmp++; if (issue_fire !== 1'b0) begin n_bad++; $display("FAIL rm_fire: got %b want 0", issue_fire); end
        tick();
        reset = 0;
        idle();
        #1;
        n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL rm_busy: got %h want 0", busy_mask); end
        n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL rm_inflight: got %0d want 0", inflight); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rm_err: got %b want 0", err); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 79) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            issue_ready = ($urandom_range(0, 3) != 0);
            ra1         = $urandom_range(0, 1) ? pick() : 5'($urandom_range(0, 7));
            ra2         = $urandom_range(0, 1) ? pick() : 5'($urandom_range(0, 7));
            use_ra1     = 1'($urandom_range(0, 1));
            use_ra2     = 1'($urandom_range(0, 1));
            id_rd       = 5'($urandom_range(0, 7));
            id_wen      = ($urandom_range(0, 3) != 0);
            wb_valid    = ($urandom_range(0, 1) != 0);
            wb_rd       = pick();
            kill_valid  = ($urandom_range(0, 5) == 0);
            kill_rd     = pick();
            #1;
            n_cmp++; if (stall_d !== m_stall()) begin n_bad++; $display("FAIL rnd_stall @%0d: got %b want %b", i, stall_d, m_stall()); end
            n_cmp++; if (issue_fire !== m_fire()) begin n_bad++; $display("FAIL rnd_fire @%0d: got %b want %b", i, issue_fire, m_fire()); end
            n_cmp++; if (busy_mask !== m_busy()) begin n_bad++; $display("FAIL rnd_busy @%0d: got %h want %h", i, busy_mask, m_busy()); end
            n_cmp++; if (inflight !== 3'(m_inflight())) begin n_bad++; $display("FAIL rnd_inflight @%0d: got %0d want %0d", i, inflight, m_inflight()); end
            n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err @%0d: got %b want %b", i, err, m_err); end
            tick();
        end
        reset = 0;
        idle();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        m_err = 1'b0;
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_bypass();
        test_capacity();
        test_dest_sat();
        test_x0_underflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
